// File: rtl/zero_flag_pipe_if.sv
// Handshake bundle for zero_flag_pipe: the result/mode input side, the flag output
// side and the sticky flag.
interface zero_flag_pipe_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_flag;
    logic             out_neg;
    logic             sticky_flag;
    logic             sticky_clr;

    modport master (
        output in_valid, in_result, in_mode, out_ready, sticky_clr,
        input  in_ready, out_valid, out_flag, out_neg, sticky_flag
    );

    modport slave (
        input  in_valid, in_result, in_mode, out_ready, sticky_clr,
        output in_ready, out_valid, out_flag, out_neg, sticky_flag
    );
endinterface

// File: rtl/zero_flag_pipe.sv
// Pipelined zero / all-ones detector: a registered CHUNK-ary OR/AND reduction tree
// with a single global advance, plus sign passthrough and a sticky flag.
module zero_flag_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            reset,
    zero_flag_pipe_if.slave bus
);

    function automatic int levelWidth(input int level);
        int n;
        n = WIDTH;
        for (int i = 0; i < level; i++) begin
            n = (n + CHUNK - 1) / CHUNK;
        end
        return n;
    endfunction

    function automatic int calcLevels();
        int n;
        int l;
        n = WIDTH;
        l = 0;
        while (n > 1) begin
            n = (n + CHUNK - 1) / CHUNK;
            l++;
        end
        return l;
    endfunction

    // Bit offset of stage s's node bits inside the packed intermediate register.
    function automatic int midOffset(input int s);
        int sum;
        sum = 0;
        for (int j = 1; j <= s; j++) begin
            sum += levelWidth(j);
        end
        return sum;
    endfunction

    localparam int LEVELS     = calcLevels();
    localparam int MID_STAGES = (LEVELS > 1) ? LEVELS - 1 : 1;
    localparam int MID_BITS   = (LEVELS > 1) ? midOffset(LEVELS - 1) : 1;

    logic [LEVELS-1:0]     r_valid;
    logic [MID_BITS-1:0]   r_mid;
    logic [MID_STAGES-1:0] r_mode;
    logic [MID_STAGES-1:0] r_neg;
    logic                  r_outFlag;
    logic                  r_outNeg;
    logic                  r_sticky;

    logic                  w_adv;
    logic                  w_xferOut;
    logic [LEVELS-1:0]     w_validNext;
    logic [MID_BITS-1:0]   w_midNext;
    logic [MID_STAGES-1:0] w_modeNext;
    logic [MID_STAGES-1:0] w_negNext;
    logic                  w_flagNext;
    logic                  w_negOutNext;

    assign w_adv     = ~r_valid[LEVELS-1] | bus.out_ready;
    assign w_xferOut = r_valid[LEVELS-1] & bus.out_ready;

    if (LEVELS == 1) begin : g_noMid
        assign w_midNext  = '0;
        assign w_modeNext = '0;
        assign w_negNext  = '0;
    end

    for (genvar s = 0; s < LEVELS; s++) begin : g_stage
        localparam int IN_W  = levelWidth(s);
        localparam int OUT_W = levelWidth(s + 1);

        logic [IN_W-1:0]        w_src;
        logic                   w_srcMode;
        logic                   w_srcNeg;
        logic [OUT_W*CHUNK-1:0] w_padded;
        logic [OUT_W-1:0]       w_red;

        if (s == 0) begin : g_first
            assign w_src          = bus.in_result;
            assign w_srcMode      = bus.in_mode;
            assign w_srcNeg       = bus.in_result[WIDTH-1];
            assign w_validNext[0] = bus.in_valid;
        end else begin : g_inner
            localparam int SRC_OFF = midOffset(s - 1);
            assign w_src          = r_mid[SRC_OFF +: IN_W];
            assign w_srcMode      = r_mode[s-1];
            assign w_srcNeg       = r_neg[s-1];
            assign w_validNext[s] = r_valid[s-1];
        end

        // Short last group is filled with the identity of the active operator.
        always_comb begin
            w_padded = {(OUT_W*CHUNK){w_srcMode}};
            w_padded[IN_W-1:0] = w_src;
            w_red = '0;
            for (int j = 0; j < OUT_W; j++) begin
                if (w_srcMode) begin
                    w_red[j] = &w_padded[j*CHUNK +: CHUNK];
                end else begin
                    w_red[j] = |w_padded[j*CHUNK +: CHUNK];
                end
            end
        end

        if (s < LEVELS - 1) begin : g_mid
            localparam int DST_OFF = midOffset(s);
            assign w_midNext[DST_OFF +: OUT_W] = w_red;
            assign w_modeNext[s] = w_srcMode;
            assign w_negNext[s]  = w_srcNeg;
        end else begin : g_last
            assign w_flagNext   = w_srcMode ? w_red[0] : ~w_red[0];
            assign w_negOutNext = w_srcNeg;
        end
    end

    // Final stage keeps its flag outputs when a bubble arrives, so they hold the last result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= '0;
            r_mid     <= '0;
            r_mode    <= '0;
            r_neg     <= '0;
            r_outFlag <= 1'b0;
            r_outNeg  <= 1'b0;
        end else if (w_adv) begin
            r_valid <= w_validNext;
            r_mid   <= w_midNext;
            r_mode  <= w_modeNext;
            r_neg   <= w_negNext;
            if (w_validNext[LEVELS-1]) begin
                r_outFlag <= w_flagNext;
                r_outNeg  <= w_negOutNext;
            end
        end
    end

    // A clear coinciding with a transfer still records that transfer's flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= 1'b0;
        end else if (bus.sticky_clr) begin
            r_sticky <= w_xferOut & r_outFlag;
        end else if (w_xferOut) begin
            r_sticky <= r_sticky | r_outFlag;
        end
    end

    assign bus.in_ready    = w_adv;
    assign bus.out_valid   = r_valid[LEVELS-1];
    assign bus.out_flag    = r_outFlag;
    assign bus.out_neg     = r_outNeg;
    assign bus.sticky_flag = r_sticky;

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Bench for zero_flag_pipe: directed and randomised traffic on a 32/4 instance against
// a transaction-level model, plus padding cases on a 10/4 instance.
module tb_zero_flag_pipe;

    logic clk = 1'b0;
    logic reset;
    int   testsRun    = 0;
    int   testsFailed = 0;

    zero_flag_pipe_if #(.WIDTH(32)) busA ();
    zero_flag_pipe_if #(.WIDTH(10)) busB ();

    zero_flag_pipe #(.WIDTH(32), .CHUNK(4)) u_dutA (.clk(clk), .reset(reset), .bus(busA));
    zero_flag_pipe #(.WIDTH(10), .CHUNK(4)) u_dutB (.clk(clk), .reset(reset), .bus(busB));

    always #5 clk = ~clk;

    // Transaction model of the 32-bit instance: three slots of whole results in flight.
    logic        mValid [3];
    logic [31:0] mData  [3];
    logic        mMode  [3];
    logic        mFlag;
    logic        mNeg;
    logic        mSticky;

    function automatic logic refFlag(input logic [31:0] v, input int w, input logic m);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (m) return (v & mask) == mask;
        return (v & mask) == 32'd0;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mValid[k] = 1'b0;
            mData[k]  = 32'd0;
            mMode[k]  = 1'b0;
        end
        mFlag   = 1'b0;
        mNeg    = 1'b0;
        mSticky = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic m,
                                 input logic ordy, input logic clr);
        busA.in_valid   = v;
        busA.in_result  = d;
        busA.in_mode    = m;
        busA.out_ready  = ordy;
        busA.sticky_clr = clr;
    endtask

    // One clock of the 32-bit instance: drive, check against the model, advance the model.
    task automatic stepA(input logic v, input logic [31:0] d, input logic m,
                         input logic ordy, input logic clr);
        logic expReady;
        logic adv;
        logic outX;
        applyStimulus(v, d, m, ordy, clr);
        #1;
        expReady = ~mValid[2] | ordy;
        checkOutput("a_in_ready", busA.in_ready, expReady);
        checkOutput("a_out_valid", busA.out_valid, mValid[2]);
        checkOutput("a_sticky", busA.sticky_flag, mSticky);
        if (mValid[2]) begin
            checkOutput("a_out_flag", busA.out_flag, mFlag);
            checkOutput("a_out_neg", busA.out_neg, mNeg);
        end
        adv  = ~mValid[2] | ordy;
        outX = mValid[2] & ordy;
        if (clr) mSticky = outX & mFlag;
        else if (outX) mSticky = mSticky | mFlag;
        if (adv) begin
            if (mValid[1]) begin
                mFlag = refFlag(mData[1], 32, mMode[1]);
                mNeg  = mData[1][31];
            end
            for (int k = 2; k > 0; k--) begin
                mValid[k] = mValid[k-1];
                mData[k]  = mData[k-1];
                mMode[k]  = mMode[k-1];
            end
            mValid[0] = v;
            mData[0]  = d;
            mMode[0]  = m;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runB(input string tag, input logic [9:0] d, input logic m,
                        input logic expFlag, input logic expNeg);
        busB.in_valid  = 1'b1;
        busB.in_result = d;
        busB.in_mode   = m;
        @(posedge clk);
        #1;
        busB.in_valid = 1'b0;
        checkOutput({tag, "_early"}, busB.out_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, busB.out_valid, 1'b1);
        checkOutput({tag, "_flag"}, busB.out_flag, expFlag);
        checkOutput({tag, "_neg"}, busB.out_neg, expNeg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        rv;
        logic [31:0] rd;
        logic        rm;
        logic        rr;
        logic        rc;

        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        busB.in_valid   = 1'b0;
        busB.in_result  = '0;
        busB.in_mode    = 1'b0;
        busB.out_ready  = 1'b1;
        busB.sticky_clr = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", busA.out_valid, 1'b0);
        checkOutput("rst_in_ready", busA.in_ready, 1'b1);
        checkOutput("rst_sticky", busA.sticky_flag, 1'b0);
        checkOutput("rst_out_flag", busA.out_flag, 1'b0);
        checkOutput("rst_out_neg", busA.out_neg, 1'b0);
        @(posedge clk);
        #1;

        // Padding on the 10-bit instance.
        runB("pad_ones", 10'h3FF, 1'b1, 1'b1, 1'b1);
        runB("pad_notones", 10'h1FF, 1'b1, 1'b0, 1'b0);
        runB("pad_zero", 10'h200, 1'b0, 1'b0, 1'b1);

        // Latency: a zero result appears three cycles after acceptance.
        stepA(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("lat_valid", busA.out_valid, 1'b1);
        checkOutput("lat_flag", busA.out_flag, 1'b1);
        checkOutput("lat_neg", busA.out_neg, 1'b0);
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Back-to-back streaming.
        stepA(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        stepA(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        stepA(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        checkOutput("str0_flag", busA.out_flag, 1'b1);
        checkOutput("str0_neg", busA.out_neg, 1'b0);
        stepA(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        checkOutput("str1_flag", busA.out_flag, 1'b0);
        checkOutput("str1_neg", busA.out_neg, 1'b1);
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("str2_flag", busA.out_flag, 1'b0);
        checkOutput("str2_neg", busA.out_neg, 1'b0);
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("str3_flag", busA.out_flag, 1'b1);
        checkOutput("str3_neg", busA.out_neg, 1'b1);
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Stall with the pipe full, then drain in order.
        stepA(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        stepA(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        stepA(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        repeat (5) stepA(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_in_ready", busA.in_ready, 1'b0);
        checkOutput("stall_flag", busA.out_flag, 1'b1);
        repeat (3) stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_drained", busA.out_valid, 1'b0);

        // Sticky flag behaviour.
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        stepA(1'b1, 32'h5, 1'b0, 1'b1, 1'b0);
        repeat (3) stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("sticky_after_5", busA.sticky_flag, 1'b0);
        stepA(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("sticky_after_0", busA.sticky_flag, 1'b1);
        stepA(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("sticky_clr_xfer", busA.sticky_flag, 1'b1);
        stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("sticky_clr_only", busA.sticky_flag, 1'b0);

        // Randomised traffic with mixed modes, stalls and clears.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       rd = 32'h0;
                1:       rd = 32'hFFFF_FFFF;
                2:       rd = 32'hFFFF_FFFF ^ (32'd1 << $urandom_range(0, 31));
                3:       rd = 32'd1 << $urandom_range(0, 31);
                default: rd = $urandom;
            endcase
            rm = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 15) == 0);
            stepA(rv, rd, rm, rr, rc);
        end

        // Reset in mid-stream discards the stalled contents.
        stepA(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        stepA(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        stepA(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", busA.out_valid, 1'b0);
        checkOutput("midrst_sticky", busA.sticky_flag, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("midrst_in_ready", busA.in_ready, 1'b1);
        @(posedge clk);
        #1;
        repeat (5) stepA(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
